// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types for the memory port arbiter: the arbiter state, the
//   encoding of which requester currently owns the SRAM, and the helper
//   that sizes the access wait counter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_MEM  = 2'd2
  } owner_e;

  localparam int WAIT_CYCLES_DEF = 2;

  // Counter must hold values 0..wait_cycles.
  function automatic int cnt_width(input int wait_cycles);
    int w;
    w = $clog2(wait_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int CNT_W = cnt_width(WAIT_CYCLES_DEF);

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// wait_counter
//   Counts the cycles of one multi-cycle memory access. load starts a new
//   access at count 1, en advances the count, clear returns it to 0, and
//   done is high while the count sits at LIMIT.
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous reset, active-high
//   load   in   start of an access (count <= 1)
//   clear  in   end of an access (count <= 0)
//   en     in   advance the count (saturates at LIMIT)
//   done   out  count == LIMIT
import mem_port_arbiter_pkg::*;

module wait_counter #(
  parameter int LIMIT = WAIT_CYCLES_DEF,
  parameter int CW    = cnt_width(LIMIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  input  logic en,
  output logic done
);

  logic [CW-1:0] count;

  assign done = (count == CW'(LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(1);
    end else if (clear) begin
      count <= '0;
    end else if (en && !done) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port SRAM between the fetch stage (read-only) and the
//   memory stage (read/write). Each granted access holds sram_en for
//   WAIT_CYCLES cycles, then the owner gets a one-cycle ready pulse with
//   registered read data. Stalls are the combinational freeze signals for
//   the pipeline. A taken branch (if_cancel) squashes a fetch.
//
// Ports
//   clk, rst                  clock / synchronous active-high reset
//   if_req/if_addr            fetch read request, held until if_ready
//   if_cancel                 branch taken: squash current or pending fetch
//   if_ready/if_rdata         fetch completion pulse and instruction
//   if_stall                  if_req & ~if_ready
//   mem_req/mem_we/mem_addr/mem_wdata   data request, held until mem_ready
//   mem_ready/mem_rdata       data completion pulse and read data (0 on write)
//   mem_stall                 mem_req & ~mem_ready
//   sram_en/sram_we/sram_addr/sram_wdata   SRAM control, registered
//   sram_rdata                SRAM read data, valid in the last access cycle
//
// state  | meaning
// IDLE   | no access; grant mem_req first, then (if_req & ~if_cancel)
// ACCESS | sram_en high, counting WAIT_CYCLES; fetch may be aborted here
// DONE   | owner's ready pulse for one cycle, then back to IDLE
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_cancel,
  output logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_stall,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_stall,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam int CW = cnt_width(WAIT_CYCLES);

  arb_state_e state_q;
  owner_e     owner_q;
  logic       if_ready_q;
  logic       cnt_done;
  logic       grant_mem;
  logic       grant_if;
  logic       if_abort;
  logic       in_access;

  assign in_access = (state_q == ACCESS);
  assign grant_mem = (state_q == IDLE) && mem_req;
  assign grant_if  = (state_q == IDLE) && !mem_req && if_req && !if_cancel;
  assign if_abort  = in_access && (owner_q == OWNER_IF) && if_cancel;

  wait_counter #(
    .LIMIT (WAIT_CYCLES),
    .CW    (CW)
  ) u_wait_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (grant_mem || grant_if),
    .clear (in_access && (cnt_done || if_abort)),
    .en    (in_access && !if_abort),
    .done  (cnt_done)
  );

  // A branch arriving while the fetch result is being returned kills it.
  assign if_ready  = if_ready_q && !if_cancel;
  assign if_stall  = if_req && !if_ready;
  assign mem_stall = mem_req && !mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWNER_NONE;
      if_ready_q <= 1'b0;
      mem_ready  <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      if_ready_q <= 1'b0;
      mem_ready  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_mem) begin
            state_q    <= ACCESS;
            owner_q    <= OWNER_MEM;
            sram_en    <= 1'b1;
            sram_we    <= mem_we;
            sram_addr  <= mem_addr;
            sram_wdata <= mem_wdata;
          end else if (grant_if) begin
            state_q   <= ACCESS;
            owner_q   <= OWNER_IF;
            sram_en   <= 1'b1;
            sram_we   <= 1'b0;
            sram_addr <= if_addr;
          end
        end
        ACCESS: begin
          if (if_abort) begin
            state_q <= IDLE;
            owner_q <= OWNER_NONE;
            sram_en <= 1'b0;
            sram_we <= 1'b0;
          end else if (cnt_done) begin
            state_q <= DONE;
            sram_en <= 1'b0;
            sram_we <= 1'b0;
            if (owner_q == OWNER_MEM) begin
              mem_rdata <= sram_we ? '0 : sram_rdata;
              mem_ready <= 1'b1;
            end else begin
              if_rdata   <= sram_rdata;
              if_ready_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          owner_q <= OWNER_NONE;
        end
        default: begin
          state_q <= IDLE;
          owner_q <= OWNER_NONE;
          sram_en <= 1'b0;
          sram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_cancel, if_ready, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_we, mem_ready, mem_stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        sram_en, sram_we;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_ready(if_ready), .if_rdata(if_rdata), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: data is only presented in the last cycle of an access.
  function automatic logic [31:0] sram_model(input logic [31:0] a);
    case (a)
      32'h0000_0008: return 32'hE3A0_1005;
      32'h0000_0100: return 32'h0000_00AA;
      32'h0000_0200: return 32'h1111_2222;
      32'h0000_0300: return 32'h3333_4444;
      32'hFFFF_FFFC: return 32'hC0DE_C0DE;
      default:       return a ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  int en_run = 0;
  logic prev_en = 1'b0;
  int grants = 0;
  always @(posedge clk) begin
    en_run  <= sram_en ? en_run + 1 : 0;
    prev_en <= sram_en;
    if (sram_en && !prev_en) grants <= grants + 1;
  end
  assign sram_rdata = (sram_en && en_run == W - 1) ? sram_model(sram_addr) : 32'h0BAD_0BAD;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic        is_mem;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];
  logic [31:0] last_if_exp = 32'h0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (if_ready || mem_ready)) begin
      check1("rdy_excl", if_ready & mem_ready, 1'b0);
      check1("rdy_sram_off", sram_en, 1'b0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready cyc=%0d if_ready=%b mem_ready=%b", cyc, if_ready, mem_ready);
      end else begin
        e = exp_q.pop_front();
        check1("rdy_port", mem_ready, e.is_mem);
        check("rdy_data", e.is_mem ? mem_rdata : if_rdata, e.data);
        check("rdy_cycle", cyc, e.cyc);
        if (!e.is_mem) last_if_exp = e.data;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int t0;
    step();
    if (v.is_mem) begin
      mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    t0 = cyc;
    exp_q.push_back('{v.is_mem, v.exp_rdata, t0 + W + 1});
    #1;
    check1("v_stall_c0", v.is_mem ? mem_stall : if_stall, 1'b1);
    check1("v_en_c0", sram_en, 1'b0);
    for (int k = 1; k <= W + 1; k++) begin
      step();
      check1("v_sram_en", sram_en, k <= W);
      check1("v_sram_we", sram_we, (k <= W) && v.is_mem && v.we);
      if (k <= W) begin
        check("v_sram_addr", sram_addr, v.addr);
        if (v.is_mem && v.we) check("v_sram_wdata", sram_wdata, v.wdata);
      end
    end
    check1("v_stall_rdy", v.is_mem ? mem_stall : if_stall, 1'b0);
    step();
    if_req = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    int t0;
    int g0;
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'hE3A0_1005};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_00AA};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0, 32'h1111_2222};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hC0DE_C0DE};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'h3333_4444};

    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'h0; if_cancel = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    repeat (3) step();
    check1("rst_if_ready", if_ready, 1'b0);
    check1("rst_mem_ready", mem_ready, 1'b0);
    check1("rst_sram_en", sram_en, 1'b0);
    check1("rst_sram_we", sram_we, 1'b0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_sram_addr", sram_addr, 32'h0);
    check("rst_sram_wdata", sram_wdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Simultaneous requests: MEM first, IF granted right after DONE.
    step();
    t0 = cyc;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h8;
    exp_q.push_back('{1'b1, 32'h0000_00AA, t0 + 3});
    exp_q.push_back('{1'b0, 32'hE3A0_1005, t0 + 7});
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) step();
      if (c == 4) mem_req = 1'b0;
      #1;
      check1("arb_if_stall", if_stall, c < 7);
      check1("arb_mem_stall", mem_stall, c < 3);
      check1("arb_sram_en", sram_en, c inside {1, 2, 5, 6});
      if (c == 1) check("arb_addr_mem", sram_addr, 32'h100);
      if (c == 5) check("arb_addr_if", sram_addr, 32'h8);
    end
    step();
    if_req = 1'b0;

    // Cancel during ACCESS, then cancel masking a request in IDLE.
    step();
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h300;
    step();
    if_cancel = 1'b1;
    #1 check1("cx_en_c1", sram_en, 1'b1);
    step();
    if_addr = 32'h200;
    #1;
    check1("cx_en_c2", sram_en, 1'b0);
    check1("cx_no_ready", if_ready, 1'b0);
    check("cx_rdata_held", if_rdata, last_if_exp);
    step();
    if_cancel = 1'b0;
    exp_q.push_back('{1'b0, 32'h1111_2222, t0 + 6});
    #1 check1("cx_idle_mask", sram_en, 1'b0);
    step();
    check1("cx_regrant_en", sram_en, 1'b1);
    check("cx_regrant_addr", sram_addr, 32'h200);
    step();
    step();
    step();
    if_req = 1'b0;

    // Cancel arriving in DONE suppresses the ready pulse.
    step();
    if_req = 1'b1; if_addr = 32'h8;
    step();
    step();
    step();
    if_cancel = 1'b1;
    #1;
    check1("cd_ready_forced", if_ready, 1'b0);
    check1("cd_stall", if_stall, 1'b1);
    step();
    if_cancel = 1'b0;
    if_req = 1'b0;

    // Reset in the last cycle of a MEM access abandons it.
    step();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    step();
    step();
    rst = 1'b1;
    mem_req = 1'b0;
    step();
    check1("mr_sram_en", sram_en, 1'b0);
    check1("mr_mem_ready", mem_ready, 1'b0);
    check("mr_mem_rdata", mem_rdata, 32'h0);
    check("mr_if_rdata", if_rdata, 32'h0);
    check("mr_sram_addr", sram_addr, 32'h0);
    rst = 1'b0;
    repeat (5) step();

    // Request held one cycle past ready: a second full access, one pulse each.
    step();
    g0 = grants;
    t0 = cyc;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300;
    exp_q.push_back('{1'b1, 32'h3333_4444, t0 + 3});
    exp_q.push_back('{1'b1, 32'h3333_4444, t0 + 7});
    for (int c = 1; c <= 8; c++) begin
      step();
      check1("hold_en", sram_en, c inside {1, 2, 5, 6});
    end
    mem_req = 1'b0;
    repeat (4) step();
    check("hold_grants", grants - g0, 2);

    check("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates one single-port instruction/data memory between the fetch stage (read-only) and the memory stage (read/write). It sequences each access over a fixed number of wait cycles and returns a one-cycle ready pulse with registered read data. It generates the stall signals the pipeline uses as freeze. A taken branch can cancel an in-flight fetch.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
WAIT_CYCLES, 2, cycles sram_en is held per access (legal range >=1)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
if_req  in  1  fetch read request; held until if_ready
if_addr  in  ADDR_WIDTH  fetch address (PC)
if_cancel  in  1  branch taken; squash the current or pending fetch
if_ready  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  DATA_WIDTH  fetched instruction
if_stall  out  1  if_req & ~if_ready (combinational); drives fetch freeze
mem_req  in  1  data request; held until mem_ready
mem_we  in  1  1 = write, 0 = read; sampled at grant
mem_addr  in  ADDR_WIDTH  data address
mem_wdata  in  DATA_WIDTH  write data
mem_ready  out  1  one-cycle pulse; access complete
mem_rdata  out  DATA_WIDTH  read data (0 after a write)
mem_stall  out  1  mem_req & ~mem_ready (combinational)
sram_en  out  1  memory access enable
sram_we  out  1  memory write enable
sram_addr  out  ADDR_WIDTH  memory address
sram_wdata  out  DATA_WIDTH  memory write data
sram_rdata  in  DATA_WIDTH  memory read data, valid during the last access cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, owner=NONE, wait counter=0. if_ready, mem_ready, sram_en and sram_we are 0. if_rdata, mem_rdata, sram_addr and sram_wdata are 0. A reset mid-access abandons the access; no ready pulse follows.
- FSM states:
  - IDLE: grant on the next edge.
    - Priority is mem_req over (if_req & ~if_cancel).
    - At grant, latch owner, addr, wdata and we into registers, then go to ACCESS.
    - With no request, stay in IDLE.
  - ACCESS: sram_en=1. sram_addr, sram_wdata and sram_we come from the latched registers (sram_we=0 for fetch).
    - The counter counts 1..WAIT_CYCLES.
    - On the edge ending cycle WAIT_CYCLES, capture sram_rdata into the owner's rdata register (mem_rdata<=0 for a write), then go to DONE.
  - DONE: the owner's ready=1 for exactly one cycle; sram_en=0. Go to IDLE next edge. Requesters drop req on that same edge, which prevents a double grant.
- Latency: a req seen in IDLE at cycle 0 gives ready in cycle WAIT_CYCLES+1. The earliest next grant decision is cycle WAIT_CYCLES+2. Sustained throughput is one access per WAIT_CYCLES+2 cycles.
- Fetch cancel:
  - if_cancel high while owner=IF in ACCESS: abort. Go to IDLE next edge, sram_en drops, if_rdata is unchanged and no if_ready.
  - if_cancel high in DONE with owner=IF: if_ready is forced 0.
  - if_cancel in IDLE: masks if_req for that cycle only.
  - The fetch stage re-requests the branch target afterwards.
- Memory-stage accesses are never cancelled or preempted.
- Simultaneous requests: MEM wins. IF waits with if_stall=1. No fairness counter is required; the memory stage issues at most one access per instruction.
- Outputs hold their last values outside their ready cycle, except the ready pulses themselves.
- Address and data are passed through unmodified; alignment is the requester's responsibility.

Decomposition:
- Shared package holds:
  - the state enum IDLE/ACCESS/DONE (2 bits)
  - the owner encoding NONE/IF/MEM
  - the localparam CNT_W = clog2(WAIT_CYCLES+1)
- One sub-module is natural: wait_counter (load/clear, count-enable, done flag at WAIT_CYCLES). It is reusable by other multi-cycle memory controllers.

Test Plan:
- WAIT_CYCLES=2, if_req=1, if_addr=0x0000_0008, sram returns 0xE3A0_1005 -> sram_en high cycles 1-2, if_ready pulse cycle 3 with if_rdata=0xE3A0_1005, if_stall low in cycle 3.
- if_req and mem_req (read, 0x100, sram 0x0000_00AA) both raised in cycle 0 -> MEM served first: mem_ready cycle 3 with 0xAA. Then the IF grant in cycle 4, if_ready cycle 7; if_stall high cycles 0-6.
- mem_req write, mem_addr=0x40, mem_wdata=0xDEAD_BEEF -> sram_we=1, sram_addr=0x40, sram_wdata=0xDEAD_BEEF in cycles 1-2; mem_ready cycle 3, mem_rdata=0.
- Fetch granted, if_cancel=1 in cycle 1 -> sram_en=0 from cycle 2, state IDLE, no if_ready. A new if_req at 0x200 is then served normally.
- rst asserted in cycle 2 of a MEM access -> next cycle all outputs 0, state IDLE; no mem_ready ever pulses for that access.
- Requester holds req one extra cycle past ready (protocol check) -> exactly one ready pulse per grant; the assertion "no two grants without req deassert" holds.
